// File: rtl/csa_sub_32_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one SLICE-bit slice per clock.
// Each slice is a carry-select unit; the running carry picks the variant.
// Valid/ready handshake on both sides, one operation in flight at a time.

// One carry-select slice: a + ~b + {0,1} both precomputed, cin selects.
module csa_sub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);
    logic [SLICE:0] s0, s1;

    assign s0 = {1'b0, a_s} + {1'b0, ~b_s};
    assign s1 = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, 1'b1};
    assign {cout, sum} = cin ? s1 : s0;
endmodule

module csa_sub_32_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8     // WIDTH must be an integer multiple of SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r, b_r, wdiff, diff_next;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [SLICE-1:0] a_s, b_s, sl_sum;
    logic             sl_cout;
    logic             last;

    // Ready is gated by reset so nothing is accepted while held in reset.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (idx == IDXW'(NSLICE - 1));

    // Pick the operand slice currently being processed and splice the
    // slice result into the working difference.
    always_comb begin
        a_s       = a_r[int'(idx)*SLICE +: SLICE];
        b_s       = b_r[int'(idx)*SLICE +: SLICE];
        diff_next = wdiff;
        diff_next[int'(idx)*SLICE +: SLICE] = sl_sum;
    end

    csa_sub_slice #(.SLICE(SLICE)) u_slice (
        .a_s  (a_s),
        .b_s  (b_s),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Control FSM plus working registers; a subtract is a + ~b + ~bin,
    // so the initial carry is the inverted borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            wdiff <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= RUN;
                    a_r   <= a;
                    b_r   <= b;
                    wdiff <= '0;
                    carry <= ~bin;
                    idx   <= '0;
                end
                RUN: begin
                    wdiff <= diff_next;
                    carry <= sl_cout;
                    idx   <= idx + 1'b1;
                    if (last) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result registers update only on the final slice and otherwise hold,
    // so they stay stable through backpressure, IDLE and the next RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (state == RUN && last) begin
            diff <= diff_next;
            bout <= ~sl_cout;
            ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                    (diff_next[WIDTH-1] != a_r[WIDTH-1]);
            zero <= (diff_next == '0);
        end
    end
endmodule

// File: doc/csa_sub_32_seq.md
Name: csa_sub_32_seq

Overview:
- Multi-cycle 32-bit subtractor with borrow-in and borrow-out; the subtract counterpart of the single-cycle carry-select adder.
- Computes diff = a - b - bin one SLICE-bit slice per clock.
- Each slice uses carry-select internally: both carry-in variants are precomputed, then muxed by the running carry.
- Valid/ready handshake on input and output, for use in multi-cycle datapaths where single-cycle 32-bit timing is not required.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per RUN cycle; NSLICE = WIDTH/SLICE (default 4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  out  1  borrow out (1 when unsigned a < b + bin).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  diff == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0; diff=0, bout=0, ovf=0, zero=0; slice index=0; internal registers cleared. While rst_n is low, in_ready=0 (combinationally gated).
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN: on the edge where in_valid && in_ready.
  - Latch a, b, bin into working registers.
  - Working carry = ~bin; index = 0.
- RUN, each edge:
  - s0 = a_s + ~b_s + 0 and s1 = a_s + ~b_s + 1, each SLICE+1 bits.
  - The working carry selects one; its low SLICE bits go to working-diff slice [index].
  - Its MSB becomes the new carry; index increments.
  - Slices are processed LSB first.
- RUN -> DONE: on the edge that processes slice NSLICE-1. On that same edge, register the outputs:
  - diff = full working diff, including the final slice.
  - bout = ~final carry.
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
  - zero = (diff == 0).
- Latency: operands accepted at edge E -> out_valid=1 after edge E+NSLICE (4 cycles at default). Throughput: one result per NSLICE+2 cycles minimum.
- DONE -> IDLE: on the edge where out_valid && out_ready. out_valid falls and in_ready rises in the following cycle. No overlapped accept.
- Output hold: diff/bout/ovf/zero change only on the RUN->DONE edge. They hold the last result through IDLE and the next RUN. Consumers qualify them with out_valid.
- Backpressure: with out_ready=0 in DONE, all outputs stay stable indefinitely. in_valid is ignored.
- a, b, bin changes after acceptance have no effect.
- in_valid while in RUN/DONE is ignored. The source must hold it until in_ready; no data is lost or duplicated.
- Reset mid-RUN or mid-DONE: immediate abort to the reset values. The partial result is discarded; the next accept computes from scratch.
- Arithmetic is unsigned modulo 2^WIDTH. With bin=1 and a==b: diff = all ones, bout=1.

Test Plan:
- Reset: rst_n=0 -> in_ready=0, out_valid=0, diff=0, flags 0. Release -> in_ready=1 next cycle, state IDLE.
- a=0x00000005, b=0x00000003, bin=0 accepted at edge E -> out_valid=1 after edge E+4; diff=0x00000002, bout=0, ovf=0, zero=0.
- Full borrow ripple across all slices:
  - a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0.
  - a=b=0x12345678, bin=1 -> diff=0xFFFFFFFF, bout=1.
  - a=b=0x12345678, bin=0 -> diff=0, zero=1, bout=0.
- Signed overflow:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, bout=0.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, bout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands.
  - Outputs stable, in_ready=0, new operands not taken.
  - Then out_ready=1 -> IDLE, in_ready=1 the next cycle; the new operands are accepted and produce the correct result 4 cycles later.
- Reset after 2 RUN cycles of a=0xFFFFFFFF, b=0x1 -> all outputs return to 0.
  - Then a=0x10, b=0x8 -> diff=0x8, with no residue from the aborted operation.
- Randomized back-to-back: 1000 random a, b, bin with random out_ready stalls -> diff, bout, ovf, zero match the reference model every transfer; exactly one out_valid handshake per accepted input.
